vga_plot_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port (plot/x/y/colour, 160x120, 3-bit colour) between NUM_REQ pixel producers, e.g. init_screen, game_plot and a future overlay.
- Replaces the top-level state-indexed output mux.
- Grants the port per burst: a burst runs from first transfer to the transfer flagged last. Bursts are granted round-robin.
- Drives registered VGA outputs and clips out-of-range pixels.

---
 rtl/vga_plot_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter
//
// Shares the VGA adapter pixel-write port (160x120, 3-bit colour) between
// NUM_REQ pixel producers. The port is granted for a whole burst: a burst runs
// from the first transfer up to and including the transfer flagged last.
// Bursts are granted round-robin. A granted requester that stays silent for
// IDLE_TIMEOUT consecutive cycles loses its grant. The pixel outputs toward
// the adapter are registered, and pixels outside the screen are dropped and
// counted.
//
// Ports:
//   CLOCK_50    in   system clock
//   rst_n       in   synchronous, active-low reset
//   req_valid   in   [NUM_REQ]      per-requester pixel valid
//   req_last    in   [NUM_REQ]      final pixel of a burst (used on transfer)
//   req_x       in   [8*NUM_REQ]    packed x, requester i at [8i+7:8i]
//   req_y       in   [7*NUM_REQ]    packed y, requester i at [7i+6:7i]
//   req_colour  in   [3*NUM_REQ]    packed colour, requester i at [3i+2:3i]
//   req_ready   out  [NUM_REQ]      equals grant
//   grant       out  [NUM_REQ]      registered one-hot grant, zero when idle
//   busy        out                 high while a grant is held
//   clip_count  out  [16]           saturating count of clipped pixels
//   vga_plot    out                 registered plot strobe
//   vga_x       out  [8]            registered x
//   vga_y       out  [7]            registered y
//   vga_colour  out  [3]            registered colour
// ---------------------------------------------------------------------------
module vga_plot_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int H_RES        = 160,
  parameter int V_RES        = 120,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [7*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [15:0]          clip_count,
  output logic                 vga_plot,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so ptr + offset can exceed NUM_REQ before wrapping.
  localparam int CW    = IDX_W + 1;
  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [8:0]       X_LIM    = 9'(H_RES);
  localparam logic [7:0]       Y_LIM    = 8'(V_RES);

  typedef enum logic {
    ST_IDLE,
    ST_GRANTED
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   g_q;        // index of the granted requester
  logic [IDX_W-1:0]   ptr_q;      // round-robin start point
  logic [CNT_W-1:0]   idle_cnt_q;
  logic               plot_q;
  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic [2:0]         colour_q;
  logic [15:0]        clip_q;

  logic [NUM_REQ-1:0] grant_d;
  logic [IDX_W-1:0]   ptr_d;

  // Per-requester views of the packed data buses.
  logic [7:0] x_arr      [NUM_REQ];
  logic [6:0] y_arr      [NUM_REQ];
  logic [2:0] colour_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr[gi]      = req_x[8*gi +: 8];
    assign y_arr[gi]      = req_y[7*gi +: 7];
    assign colour_arr[gi] = req_colour[3*gi +: 3];
  end

  // Round-robin pick: first valid requester at or after ptr_q, wrapping.
  // Scanning from the far end downward lets the closest candidate win.
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [CW-1:0]    cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_d          = '0;
    grant_d[sel_idx] = 1'b1;
  end

  // Pointer value after releasing requester g_q.
  assign ptr_d = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);

  // grant_q is zero outside GRANTED, so a transfer needs no state qualifier.
  logic       xfer;
  logic       xfer_last;
  logic       release_now;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic       in_range;

  assign xfer        = |(req_valid & grant_q);
  assign xfer_last   = |(req_last & grant_q);
  // A last-pixel transfer always wins; the timeout only applies on a silent
  // cycle, so the two can never both be taken.
  assign release_now = xfer ? xfer_last : (idle_cnt_q == CNT_LAST);

  assign sel_x      = x_arr[g_q];
  assign sel_y      = y_arr[g_q];
  assign sel_colour = colour_arr[g_q];
  assign in_range   = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      g_q        <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      clip_q     <= '0;
    end else begin
      // Pixel pipeline: one registered stage toward the adapter.
      plot_q <= 1'b0;
      if (xfer) begin
        if (in_range) begin
          plot_q   <= 1'b1;
          x_q      <= sel_x;
          y_q      <= sel_y;
          colour_q <= sel_colour;
        end else if (clip_q != 16'hFFFF) begin
          clip_q <= clip_q + 16'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_q    <= ST_GRANTED;
            grant_q    <= grant_d;
            g_q        <= sel_idx;
            idle_cnt_q <= '0;
          end
        end
        ST_GRANTED: begin
          if (release_now) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= ptr_d;
            idle_cnt_q <= '0;
          end else if (xfer) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign req_ready  = grant_q;
  assign busy       = (state_q == ST_GRANTED);
  assign clip_count = clip_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_arbiter
//
// Self-checking bench for vga_plot_arbiter (NUM_REQ=3, 160x120, timeout 64).
// A cycle-level reference model tracks the owner of the port, the
// round-robin pointer, the idle count and the expected pixel outputs; a
// pixel queue cross-checks that every accepted on-screen pixel is plotted
// exactly once and in order. Directed table vectors, hand-written corner
// sequences and a randomized burst driver all run through the same cycle task.
// ---------------------------------------------------------------------------
module tb_vga_plot_arbiter;

  localparam int N = 3;

  logic           CLOCK_50 = 1'b0;
  logic           rst_n    = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [15:0]    clip_count;
  logic           vga_plot;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;

  vga_plot_arbiter #(
    .NUM_REQ(N), .H_RES(160), .V_RES(120), .IDLE_TIMEOUT(64)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_colour(req_colour),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .clip_count(clip_count),
    .vga_plot  (vga_plot),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int c; } pix_t;
  pix_t sb[$];

  int m_owner;   // -1 when nobody holds the port
  int m_ptr;
  int m_idle;
  int m_xfer;    // requester that transfers this cycle, -1 if none
  bit m_plot;
  int m_x, m_y, m_c, m_clip;

  task automatic model_step();
    int  px, py, pc;
    bit  found;
    pix_t p;
    m_xfer = -1;
    if (rst_n !== 1'b1) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_plot = 1'b0;
      m_x = 0; m_y = 0; m_c = 0; m_clip = 0;
      sb.delete();
      return;
    end
    if (m_owner >= 0 && req_valid[m_owner]) m_xfer = m_owner;
    m_plot = 1'b0;
    if (m_xfer >= 0) begin
      px = int'(req_x[8*m_xfer +: 8]);
      py = int'(req_y[7*m_xfer +: 7]);
      pc = int'(req_colour[3*m_xfer +: 3]);
      if (px < 160 && py < 120) begin
        m_plot = 1'b1; m_x = px; m_y = py; m_c = pc;
        p.x = px; p.y = py; p.c = pc;
        sb.push_back(p);
      end else if (m_clip < 65535) begin
        m_clip++;
      end
    end
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_idle  = 0;
        end
      end
    end else if (m_xfer >= 0) begin
      if (req_last[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else begin
        m_idle = 0;
      end
    end else if (m_idle == 63) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else begin
      m_idle++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input bit v, input bit l, input int x, input int y, input int c);
    req_valid[i]          = v;
    req_last[i]           = l;
    req_x[8*i +: 8]       = 8'(x);
    req_y[7*i +: 7]       = 7'(y);
    req_colour[3*i +: 3]  = 3'(c);
  endtask

  bit       drv_on;
  bit [N-1:0] drv_mask;
  int rem[N], pause[N], gap[N];
  int len_min, len_max, gap_max, pause_pct, long_pct, oor_pct;

  task automatic new_pixel(input int i);
    int x, y;
    if ($urandom_range(0, 99) < oor_pct) begin
      case ($urandom_range(0, 2))
        0:       begin x = $urandom_range(160, 255); y = $urandom_range(0, 119); end
        1:       begin x = $urandom_range(0, 159);   y = $urandom_range(120, 127); end
        default: begin x = $urandom_range(160, 255); y = $urandom_range(120, 127); end
      endcase
    end else begin
      x = $urandom_range(0, 159);
      y = $urandom_range(0, 119);
    end
    set_req(i, req_valid[i], rem[i] == 1, x, y, $urandom_range(0, 7));
  endtask

  task automatic start_burst(input int i);
    rem[i] = $urandom_range(len_min, len_max);
    new_pixel(i);
    req_valid[i] = 1'b1;
  endtask

  // Advances each requester's burst after the edge; data only changes on a
  // transfer or while valid is low, so waiting requesters hold steady.
  task automatic driver_update();
    if (!drv_on) return;
    for (int i = 0; i < N; i++) begin
      if (i == m_xfer) begin
        rem[i]--;
        if (rem[i] == 0) begin
          gap[i] = $urandom_range(0, gap_max);
          if (drv_mask[i] && gap[i] == 0) start_burst(i);
          else req_valid[i] = 1'b0;
        end else begin
          new_pixel(i);
          if ($urandom_range(0, 99) < pause_pct) begin
            pause[i] = ($urandom_range(0, 99) < long_pct) ? $urandom_range(60, 68)
                                                           : $urandom_range(1, 4);
            req_valid[i] = 1'b0;
          end
        end
      end else if (!req_valid[i]) begin
        if (rem[i] > 0) begin
          if (pause[i] > 0) pause[i]--;
          if (pause[i] == 0) req_valid[i] = 1'b1;
        end else if (drv_mask[i]) begin
          if (gap[i] > 0) gap[i]--;
          else start_burst(i);
        end
      end
    end
  endtask

  // One clock: model predicts, DUT steps, outputs compared after the edge.
  task automatic cycle();
    logic [38:0]  exp_s, act_s;
    logic [N-1:0] gv;
    pix_t p;
    model_step();
    @(posedge CLOCK_50);
    #1;
    gv    = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    exp_s = {gv, m_owner >= 0, m_plot, 8'(m_x), 7'(m_y), 3'(m_c), 16'(m_clip)};
    act_s = {grant, busy, vga_plot, vga_x, vga_y, vga_colour, clip_count};
    chk("model", act_s, exp_s);
    chk("ready", req_ready, gv);
    if (vga_plot === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra", vga_plot, 1'b0);
      end else begin
        p = sb.pop_front();
        chk("sb_pix", {vga_x, vga_y, vga_colour}, {8'(p.x), 7'(p.y), 3'(p.c)});
      end
    end
    driver_update();
  endtask

  task automatic do_reset();
    drv_on = 1'b0; drv_mask = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; pause[i] = 0; gap[i] = 0; end
    req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int req; bit v; bit l; int x; int y; int c;
    logic [N-1:0] e_grant; bit e_busy; bit e_plot; int e_x; int e_y; int e_c; int e_clip;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int zrun, plots, n;
    bit seen, idle_all;

    // 4-pixel burst on req0, then clipped/boundary pixels on req1 (ptr=1).
    tbl[0]  = '{0, 1, 0, 10,  5,   2, 3'b001, 1, 0,   0,   0, 0, 0};
    tbl[1]  = '{0, 1, 0, 10,  5,   2, 3'b001, 1, 1,  10,   5, 2, 0};
    tbl[2]  = '{0, 1, 0, 11,  5,   2, 3'b001, 1, 1,  11,   5, 2, 0};
    tbl[3]  = '{0, 1, 0, 12,  5,   2, 3'b001, 1, 1,  12,   5, 2, 0};
    tbl[4]  = '{0, 1, 1, 13,  5,   2, 3'b000, 0, 1,  13,   5, 2, 0};
    tbl[5]  = '{0, 0, 0, 13,  5,   2, 3'b000, 0, 0,  13,   5, 2, 0};
    tbl[6]  = '{1, 1, 0, 160, 0,   5, 3'b010, 1, 0,  13,   5, 2, 0};
    tbl[7]  = '{1, 1, 0, 160, 0,   5, 3'b010, 1, 0,  13,   5, 2, 1};
    tbl[8]  = '{1, 1, 0, 0,   120, 5, 3'b010, 1, 0,  13,   5, 2, 2};
    tbl[9]  = '{1, 1, 1, 159, 119, 5, 3'b000, 0, 1, 159, 119, 5, 2};
    tbl[10] = '{1, 0, 0, 159, 119, 5, 3'b000, 0, 0, 159, 119, 5, 2};

    len_min = 1; len_max = 1; gap_max = 0; pause_pct = 0; long_pct = 0; oor_pct = 0;

    // ---- reset state ----
    do_reset();
    chk("rst_grant", grant, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_plot", vga_plot, 1'b0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, '0);
    chk("rst_clip", clip_count, 16'd0);

    // ---- table vectors ----
    for (int i = 0; i < 11; i++) begin
      req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;
      set_req(tbl[i].req, tbl[i].v, tbl[i].l, tbl[i].x, tbl[i].y, tbl[i].c);
      cycle();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_plot", i), vga_plot, tbl[i].e_plot);
      chk($sformatf("tbl%0d_xyc", i), {vga_x, vga_y, vga_colour},
          {8'(tbl[i].e_x), 7'(tbl[i].e_y), 3'(tbl[i].e_c)});
      chk($sformatf("tbl%0d_clip", i), clip_count, 16'(tbl[i].e_clip));
    end

    // ---- idle timeout on req0 while req2 waits ----
    do_reset();
    set_req(0, 1, 0, 20, 20, 1);
    set_req(2, 1, 0, 30, 30, 4);
    cycle();
    chk("to_grant0", grant, 3'b001);
    cycle();
    chk("to_plot", vga_plot, 1'b1);
    set_req(0, 0, 0, 20, 20, 1);
    n = 0;
    while (grant != '0 && n < 200) begin
      cycle();
      n++;
    end
    chk("to_idle_cycles", n, 64);
    cycle();
    chk("to_next_grant", grant, 3'b100);

    // ---- reset in the middle of a req2 burst ----
    do_reset();
    set_req(2, 1, 0, 200, 10, 7);
    cycle();
    chk("mr_grant", grant, 3'b100);
    cycle();
    chk("mr_clip", clip_count, 16'd1);
    set_req(2, 1, 0, 40, 10, 7);
    cycle();
    chk("mr_plot", vga_plot, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mr_rst_grant", grant, 3'b000);
    chk("mr_rst_plot", vga_plot, 1'b0);
    chk("mr_rst_clip", clip_count, 16'd0);
    chk("mr_rst_busy", busy, 1'b0);
    cycle();
    chk("mr_regrant2", grant, 3'b100);
    rst_n = 1'b0;
    set_req(1, 1, 1, 5, 5, 1);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("mr_regrant1", grant, 3'b010);

    // ---- round robin, all requesters continuously valid, 2-pixel bursts ----
    do_reset();
    len_min = 2; len_max = 2; gap_max = 0; pause_pct = 0; oor_pct = 0;
    drv_mask = 3'b111; drv_on = 1'b1;
    for (int i = 0; i < N; i++) start_burst(i);
    order.delete(); zrun = 1; seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (grant != '0) begin
        if (zrun > 0) begin
          order.push_back(oh2idx(grant));
          if (seen) chk("rr_dead_cycles", zrun, 1);
          seen = 1'b1;
        end
        zrun = 0;
      end else begin
        zrun++;
      end
    end
    chk("rr_bursts", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk($sformatf("rr_order%0d", k), order[k], k % 3);

    // ---- single-pixel bursts alternating on req0/req1 ----
    do_reset();
    len_min = 1; len_max = 1; gap_max = 0;
    drv_mask = 3'b011; drv_on = 1'b1;
    start_burst(0);
    start_burst(1);
    order.delete(); zrun = 1; plots = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (vga_plot === 1'b1) plots++;
      if (grant != '0) begin
        if (zrun > 0) order.push_back(oh2idx(grant));
        zrun = 0;
      end else begin
        zrun++;
      end
    end
    chk("alt_plots", plots, 20);
    for (int k = 0; k < 6 && k < order.size(); k++)
      chk($sformatf("alt_order%0d", k), order[k], k % 2);
    chk("alt_sb_left", sb.size(), 0);

    // ---- randomized bursts, pauses, timeouts and clipped pixels ----
    do_reset();
    len_min = 1; len_max = 6; gap_max = 3; pause_pct = 15; long_pct = 4; oor_pct = 10;
    drv_mask = 3'b111; drv_on = 1'b1;
    for (int c = 0; c < 3000; c++) cycle();
    drv_mask = '0;
    n = 0;
    idle_all = 1'b0;
    while (!idle_all && n < 1000) begin
      cycle();
      n++;
      idle_all = (req_valid == '0);
      for (int i = 0; i < N; i++) if (rem[i] != 0) idle_all = 1'b0;
    end
    chk("rand_drain_in_bound", n < 1000, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    chk("rand_sb_left", sb.size(), 0);
    chk("rand_idle_grant", grant, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
